// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: Start/Busy/Done handshake and operand/result bus of the multiply/divide unit (DivZero present under DIV_ZERO_FLAG_EN).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
`ifdef DIV_ZERO_FLAG_EN
  logic             DivZero;
  modport master (output Start, Op, OperandA, OperandB, input Busy, Done, Hi, Lo, DivZero);
  modport slave  (input Start, Op, OperandA, OperandB, output Busy, Done, Hi, Lo, DivZero);
`else
  modport master (output Start, Op, OperandA, OperandB, input Busy, Done, Hi, Lo);
  modport slave  (input Start, Op, OperandA, OperandB, output Busy, Done, Hi, Lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider, one bit per clock, HI/LO result pair.
// Optional DIV_ZERO_FLAG_EN adds DivZero and an early-completing divide-by-zero path.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            Clk,
  input logic            Reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic sa, sb, dz, sa_i, sb_i, early, neg_q;
  logic [WIDTH-1:0] m, q, acc, a_raw, a_abs, b_abs;
  logic [WIDTH-1:0] acc_n, q_n, quo_f, rem_f, hi_n, lo_n;
  logic [WIDTH:0] add_t, sh_t, dif_t;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic done_r;
  logic [WIDTH-1:0] hi_r, lo_r;
`ifdef DIV_ZERO_FLAG_EN
  logic dz_r;
  assign early = bus.Op[1] & ~|bus.OperandB;
  assign bus.DivZero = dz_r;
`else
  assign early = 1'b0;
`endif
  assign bus.Busy = state != IDLE;
  assign bus.Done = done_r;
  assign bus.Hi = hi_r;
  assign bus.Lo = lo_r;
  always_comb begin
    sa_i = bus.Op[0] & bus.OperandA[WIDTH-1];
    sb_i = bus.Op[0] & bus.OperandB[WIDTH-1];
    a_abs = sa_i ? -bus.OperandA : bus.OperandA;
    b_abs = sb_i ? -bus.OperandB : bus.OperandB;
  end
  // Multiply keeps {acc,q} as the shifting product; divide keeps acc as remainder and q as dividend/quotient.
  always_comb begin
    add_t = q[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
    sh_t = {acc, q[WIDTH-1]};
    dif_t = sh_t - {1'b0, m};
    acc_n = op[1] ? (dif_t[WIDTH] ? sh_t[WIDTH-1:0] : dif_t[WIDTH-1:0]) : add_t[WIDTH:1];
    q_n = op[1] ? {q[WIDTH-2:0], ~dif_t[WIDTH]} : {add_t[0], q[WIDTH-1:1]};
    neg_q = sa ^ sb;
    prod = {acc, q};
    prod_f = neg_q ? -prod : prod;
    quo_f = dz ? '1 : neg_q ? -q : q;
    rem_f = dz ? a_raw : sa ? -acc : acc;
    hi_n = op[1] ? rem_f : prod_f[2*WIDTH-1:WIDTH];
    lo_n = op[1] ? quo_f : prod_f[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.Start) state_n = early ? FIXUP : CALC;
    else if (state == CALC && cnt == CW'(WIDTH - 1)) state_n = FIXUP;
    else if (state == FIXUP) state_n = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      done_r <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      a_raw <= '0;
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
    end else begin
      done_r <= state == FIXUP;
      if (state == IDLE && bus.Start) begin
        op <= bus.Op;
        sa <= sa_i;
        sb <= sb_i;
        dz <= bus.Op[1] & ~|bus.OperandB;
        a_raw <= bus.OperandA;
        m <= bus.Op[1] ? b_abs : a_abs;
        q <= bus.Op[1] ? a_abs : b_abs;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_n;
        q <= q_n;
        cnt <= cnt + 1'b1;
      end else if (state == FIXUP) begin
        hi_r <= hi_n;
        lo_r <= lo_n;
      end
    end
  end
`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge Clk) begin
    if (Reset) dz_r <= 1'b0;
    else dz_r <= state == FIXUP && dz;
  end
`endif
endmodule
